// File: rtl/rf_sched_pkg.sv
// Shared constants and bus payload types for the register-file write scheduler.
// Contents: XLEN / NREG / REG_IDX_W widths and wb_req_t, one register-file write.
package rf_sched_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Signal bundle between the pipeline (master) and the write scheduler (slave).
// Groups: ALU writeback request and ready, load response, load issue, decode
// source/destination indices and stall, register-file read data in and
// forwarded read data out, and the register-file write port
// (RegWr / write_reg / write_data).
interface rf_write_scheduler_if;
  import rf_sched_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;

  logic                 ld_valid;
  logic [REG_IDX_W-1:0] ld_rd;
  logic [XLEN-1:0]      ld_data;

  logic                 issue_ld;
  logic [REG_IDX_W-1:0] issue_rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] dec_rd;
  logic                 stall;

  logic [XLEN-1:0]      rf_rd1;
  logic [XLEN-1:0]      rf_rd2;
  logic [XLEN-1:0]      fwd_rd1;
  logic [XLEN-1:0]      fwd_rd2;

  logic                 RegWr;
  logic [REG_IDX_W-1:0] write_reg;
  logic [XLEN-1:0]      write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_ld, issue_rd, rs1, rs2, dec_rd,
    output rf_rd1, rf_rd2,
    input  alu_ready, stall, fwd_rd1, fwd_rd2,
    input  RegWr, write_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_ld, issue_rd, rs1, rs2, dec_rd,
    input  rf_rd1, rf_rd2,
    output alu_ready, stall, fwd_rd1, fwd_rd2,
    output RegWr, write_reg, write_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_req_t entries used to buffer ALU writebacks.
// Ports: clk, n_rst (async active-low), push/push_req, pop, head (oldest
// entry, valid when !empty), count, full, empty. Push while full and pop
// while empty are ignored.
module wb_fifo
  import rf_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register file's single write port between the load-response
// stream (always wins) and a buffered ALU writeback stream, and keeps a
// scoreboard of registers with loads in flight so decode stalls on RAW/WAW.
// Ports: clk, n_rst (async active-low), bus (rf_write_scheduler_if.slave).
// Write-port and stall outputs are combinational from state and inputs and
// are forced to 0 while n_rst is low.
// Optional feature macro: RF_BYPASS_EN -- forwards the same-cycle write data
// to decode reads of the register being written.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 n_rst,
  rf_write_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ALU_FIFO_DEPTH + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  wb_req_t          fifo_head;
  wb_req_t          alu_req;
  wb_req_t          wr_req;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             alu_acc, alu_direct, wr_en, issue_ok, stall_int;

  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (fifo_push),
    .push_req (alu_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write-port arbitration: load first, then FIFO head, then a direct ALU write.
  always_comb begin
    alu_req       = '{rd: bus.alu_rd, data: bus.alu_data};
    bus.alu_ready = n_rst & (fifo_count < CNT_W'(ALU_FIFO_DEPTH));
    alu_acc       = bus.alu_valid & bus.alu_ready;
    alu_direct    = alu_acc & fifo_empty & ~bus.ld_valid;
    fifo_push     = alu_acc & ~alu_direct & ~fifo_full;
    fifo_pop      = ~fifo_empty & ~bus.ld_valid;
    wr_en         = 1'b0;
    wr_req        = '0;
    if (bus.ld_valid) begin
      wr_en  = 1'b1;
      wr_req = '{rd: bus.ld_rd, data: bus.ld_data};
    end else if (!fifo_empty) begin
      wr_en  = 1'b1;
      wr_req = fifo_head;
    end else if (alu_acc) begin
      wr_en  = 1'b1;
      wr_req = alu_req;
    end
    // x0 writes still consume their source but never reach the register file.
    bus.RegWr      = n_rst & wr_en & (wr_req.rd != '0);
    bus.write_reg  = n_rst ? wr_req.rd   : '0;
    bus.write_data = n_rst ? wr_req.data : '0;
  end

  // Scoreboard: stall from registered pending bits; clear wins over set.
  always_comb begin
    stall_int = pending_q[bus.rs1] | pending_q[bus.rs2] | pending_q[bus.dec_rd];
    bus.stall = n_rst & stall_int;
    issue_ok  = bus.issue_ld & ~stall_int & (bus.issue_rd != '0);
    pending_d = pending_q;
    if (issue_ok) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    if (bus.ld_valid) begin
      pending_d[bus.ld_rd] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Decode read data, optionally bypassing the write in flight this cycle.
  always_comb begin
`ifdef RF_BYPASS_EN
    bus.fwd_rd1 = (bus.RegWr && (bus.write_reg == bus.rs1) && (bus.rs1 != '0))
                  ? bus.write_data : bus.rf_rd1;
    bus.fwd_rd2 = (bus.RegWr && (bus.write_reg == bus.rs2) && (bus.rs2 != '0))
                  ? bus.write_data : bus.rf_rd2;
`else
    bus.fwd_rd1 = bus.rf_rd1;
    bus.fwd_rd2 = bus.rf_rd2;
`endif
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: hand-written vector table for
// the directed scenarios, a mid-operation reset sequence, then random traffic
// checked against a queue/array reference model. Honours RF_BYPASS_EN.
module tb_rf_write_scheduler;
  import rf_sched_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rf_write_scheduler_if bus ();

  rf_write_scheduler #(.ALU_FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: ALU buffer as a queue, scoreboard as a bit array.
  wb_req_t mdl_q[$];
  bit      mdl_pend[NREG];

  function automatic bit mdl_is_pend(input logic [4:0] r);
    return (r != 5'd0) && mdl_pend[r];
  endfunction

  function automatic bit mdl_stall();
    return mdl_is_pend(bus.rs1) || mdl_is_pend(bus.rs2) || mdl_is_pend(bus.dec_rd);
  endfunction

  task automatic model_check(input string tag);
    bit          ready, acc, have, regwr;
    logic [4:0]  wrd;
    logic [31:0] wdat, f1, f2;
    ready = mdl_q.size() < DEPTH;
    acc   = bus.alu_valid && ready;
    have  = 1'b1;
    wrd   = '0;
    wdat  = '0;
    if (bus.ld_valid) begin
      wrd = bus.ld_rd; wdat = bus.ld_data;
    end else if (mdl_q.size() > 0) begin
      wrd = mdl_q[0].rd; wdat = mdl_q[0].data;
    end else if (acc) begin
      wrd = bus.alu_rd; wdat = bus.alu_data;
    end else begin
      have = 1'b0;
    end
    regwr = have && (wrd != 5'd0);
    f1 = bus.rf_rd1;
    f2 = bus.rf_rd2;
`ifdef RF_BYPASS_EN
    if (regwr && wrd == bus.rs1) f1 = wdat;
    if (regwr && wrd == bus.rs2) f2 = wdat;
`endif
    check({tag, ".ready"}, 64'(bus.alu_ready), 64'(ready));
    check({tag, ".regwr"}, 64'(bus.RegWr), 64'(regwr));
    if (regwr) begin
      check({tag, ".wreg"},  64'(bus.write_reg),  64'(wrd));
      check({tag, ".wdata"}, 64'(bus.write_data), 64'(wdat));
    end
    check({tag, ".stall"}, 64'(bus.stall),   64'(mdl_stall()));
    check({tag, ".fwd1"},  64'(bus.fwd_rd1), 64'(f1));
    check({tag, ".fwd2"},  64'(bus.fwd_rd2), 64'(f2));
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_update();
    bit ready, acc, direct, st;
    ready  = mdl_q.size() < DEPTH;
    acc    = bus.alu_valid && ready;
    direct = acc && (mdl_q.size() == 0) && !bus.ld_valid;
    st     = mdl_stall();
    if (!bus.ld_valid && mdl_q.size() > 0) mdl_q.delete(0);
    if (acc && !direct) mdl_q.push_back(wb_req_t'{rd: bus.alu_rd, data: bus.alu_data});
    if (bus.issue_ld && !st && bus.issue_rd != 5'd0) mdl_pend[bus.issue_rd] = 1'b1;
    if (bus.ld_valid) mdl_pend[bus.ld_rd] = 1'b0;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    for (int i = 0; i < NREG; i++) mdl_pend[i] = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_valid = 0;  bus.ld_rd = 0;  bus.ld_data = 0;
    bus.issue_ld = 0;  bus.issue_rd = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.dec_rd = 0;
    bus.rf_rd1 = 0; bus.rf_rd2 = 0;
  endtask

  task automatic run_cycle(input string tag);
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        alu_valid; logic [4:0] alu_rd; logic [31:0] alu_data;
    logic        ld_valid;  logic [4:0] ld_rd;  logic [31:0] ld_data;
    logic        issue_ld;  logic [4:0] issue_rd;
    logic [4:0]  rs1, rs2, dec_rd;
    logic [31:0] rf_rd1, rf_rd2;
    logic        e_ready, e_regwr; logic [4:0] e_wreg; logic [31:0] e_wdata;
    logic        e_stall;
    logic        chk_fwd; logic [31:0] e_fwd1, e_fwd2;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic il, input logic [4:0] ir,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr,
    input logic er, input logic ew, input logic [4:0] ewr, input logic [31:0] ewd,
    input logic es);
    vec_t v;
    v.alu_valid = av; v.alu_rd = ar; v.alu_data = ad;
    v.ld_valid = lv;  v.ld_rd = lr;  v.ld_data = ld;
    v.issue_ld = il;  v.issue_rd = ir;
    v.rs1 = r1; v.rs2 = r2; v.dec_rd = dr;
    v.rf_rd1 = '0; v.rf_rd2 = '0;
    v.e_ready = er; v.e_regwr = ew; v.e_wreg = ewr; v.e_wdata = ewd; v.e_stall = es;
    v.chk_fwd = 1'b0; v.e_fwd1 = '0; v.e_fwd2 = '0;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    string tag;
    clear_inputs();
    model_reset();
    n_rst = 1'b0;

    // Outputs held at 0 during reset even with live requests on the inputs.
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234_5678;
    bus.ld_valid = 1;  bus.ld_rd = 5'd3;  bus.ld_data = 32'h0000_0042;
    bus.rs1 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst.regwr", 64'(bus.RegWr),      64'(0));
    check("rst.wreg",  64'(bus.write_reg),  64'(0));
    check("rst.wdata", 64'(bus.write_data), 64'(0));
    check("rst.ready", 64'(bus.alu_ready),  64'(0));
    check("rst.stall", 64'(bus.stall),      64'(0));
    clear_inputs();
    n_rst = 1'b1;

    //            av ar     ad            lv lr     ld            il ir     rs1    rs2    drd    rdy wr wreg   wdata         stall
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(1, 5'd5,  32'hDEAD_BEEF, 0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 1, 5'd5,  32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, 5'd4,  32'h22,        1, 5'd3,  32'h11, 0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 1, 5'd3,  32'h11,        0));
    tbl.push_back(mk(1, 5'd6,  32'h33,        1, 5'd10, 32'h44, 0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 1, 5'd10, 32'h44,        0));
    tbl.push_back(mk(1, 5'd13, 32'h66,        1, 5'd11, 32'h55, 0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 1, 5'd11, 32'h55,        0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 1, 5'd4,  32'h22,        0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 1, 5'd6,  32'h33,        0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(1, 5'd0,  32'h77,        0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  1, 5'd7,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd7,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         1));
    tbl.push_back(mk(0, 5'd0,  32'h0,         1, 5'd7,  32'h99, 0, 5'd0,  5'd7,  5'd0,  5'd0,  1, 1, 5'd7,  32'h99,        1));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd7,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  1, 5'd9,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  1, 5'd20, 5'd0,  5'd0,  5'd9,  1, 0, 5'd0,  32'h0,         1));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd20, 5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  5'd0,  5'd0,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd9,  1, 0, 5'd0,  32'h0,         1));
    tbl.push_back(mk(0, 5'd0,  32'h0,         1, 5'd9,  32'h12, 0, 5'd0,  5'd0,  5'd0,  5'd9,  1, 1, 5'd9,  32'h12,        1));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,  0, 5'd0,  5'd0,  5'd0,  5'd9,  1, 0, 5'd0,  32'h0,         0));
    tbl.push_back(mk(1, 5'd8,  32'hABCD,      0, 5'd0,  32'h0,  0, 5'd0,  5'd3,  5'd8,  5'd0,  1, 1, 5'd8,  32'hABCD,      0));
    tbl[tbl.size()-1].rf_rd1  = 32'h1111;
    tbl[tbl.size()-1].chk_fwd = 1'b1;
    tbl[tbl.size()-1].e_fwd1  = 32'h1111;
`ifdef RF_BYPASS_EN
    tbl[tbl.size()-1].e_fwd2  = 32'hABCD;
`else
    tbl[tbl.size()-1].e_fwd2  = 32'h0;
`endif

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      bus.alu_valid = tbl[i].alu_valid; bus.alu_rd = tbl[i].alu_rd; bus.alu_data = tbl[i].alu_data;
      bus.ld_valid = tbl[i].ld_valid;   bus.ld_rd = tbl[i].ld_rd;   bus.ld_data = tbl[i].ld_data;
      bus.issue_ld = tbl[i].issue_ld;   bus.issue_rd = tbl[i].issue_rd;
      bus.rs1 = tbl[i].rs1; bus.rs2 = tbl[i].rs2; bus.dec_rd = tbl[i].dec_rd;
      bus.rf_rd1 = tbl[i].rf_rd1; bus.rf_rd2 = tbl[i].rf_rd2;
      @(negedge clk);
      check({tag, ".ready"}, 64'(bus.alu_ready), 64'(tbl[i].e_ready));
      check({tag, ".regwr"}, 64'(bus.RegWr),     64'(tbl[i].e_regwr));
      if (tbl[i].e_regwr) begin
        check({tag, ".wreg"},  64'(bus.write_reg),  64'(tbl[i].e_wreg));
        check({tag, ".wdata"}, 64'(bus.write_data), 64'(tbl[i].e_wdata));
      end
      check({tag, ".stall"}, 64'(bus.stall), 64'(tbl[i].e_stall));
      if (tbl[i].chk_fwd) begin
        check({tag, ".fwd1"}, 64'(bus.fwd_rd1), 64'(tbl[i].e_fwd1));
        check({tag, ".fwd2"}, 64'(bus.fwd_rd2), 64'(tbl[i].e_fwd2));
      end
      model_check({tag, ".m"});
      @(posedge clk);
      model_update();
      #1;
    end

    // Reset mid-operation: two buffered ALU writes and x12 pending.
    clear_inputs();
    bus.ld_valid = 1; bus.ld_rd = 5'd1; bus.ld_data = 32'h1;
    bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.issue_ld = 1; bus.issue_rd = 5'd12;
    run_cycle("mrst.fill0");
    bus.issue_ld = 0;
    bus.alu_rd = 5'd3; bus.alu_data = 32'h3;
    run_cycle("mrst.fill1");
    clear_inputs();
    bus.rs1 = 5'd12;
    #1;
    check("mrst.pre.regwr", 64'(bus.RegWr), 64'(1));
    check("mrst.pre.stall", 64'(bus.stall), 64'(1));
    check("mrst.pre.ready", 64'(bus.alu_ready), 64'(0));
    n_rst = 1'b0;
    #1;
    check("mrst.in.regwr", 64'(bus.RegWr),     64'(0));
    check("mrst.in.ready", 64'(bus.alu_ready), 64'(0));
    check("mrst.in.stall", 64'(bus.stall),     64'(0));
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
    #1;
    check("mrst.post.regwr", 64'(bus.RegWr),     64'(0));
    check("mrst.post.stall", 64'(bus.stall),     64'(0));
    check("mrst.post.ready", 64'(bus.alu_ready), 64'(1));
    run_cycle("mrst.post0");
    run_cycle("mrst.post1");

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bus.alu_valid = ($urandom_range(1) == 1);
      bus.alu_rd    = 5'($urandom_range(15));
      bus.alu_data  = $urandom();
      bus.ld_valid  = ($urandom_range(2) == 0);
      bus.ld_rd     = 5'($urandom_range(15));
      bus.ld_data   = $urandom();
      bus.issue_ld  = ($urandom_range(2) == 0);
      bus.issue_rd  = 5'($urandom_range(15));
      bus.rs1       = 5'($urandom_range(15));
      bus.rs2       = 5'($urandom_range(15));
      bus.dec_rd    = 5'($urandom_range(15));
      bus.rf_rd1    = $urandom();
      bus.rf_rd2    = $urandom();
      run_cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
